// File: rtl/debug_frame_capture.sv
// Host-side receiver for the tag's serial debug port: samples one status bit
// per address, aligns to the 0101 sync nibble at addresses 12-15 and presents
// each 12-bit status frame in parallel with valid/changed/error flags.
module debug_frame_capture #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned MISS_LIMIT  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             debug_clk,
  input  logic             reset,
  input  logic             debug_in,
  input  logic             capture_en,
  output logic [11:0]      frame,
  output logic             frame_valid,
  output logic             frame_changed,
  output logic             locked,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  // The oldest sample (sr[0]) is never read, so only sr[15:1] is stored.
  logic [15:1]      sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       vcnt_q, vcnt_d;
  logic [2:0]       mcnt_q, mcnt_d;
  logic [11:0]      frame_q, frame_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_changed_q, frame_changed_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;

  logic [15:0]      win;
  logic             sync_ok;
  logic             eof;
  logic             deliver;

  assign win     = {debug_in, sr_q};
  assign sync_ok = (win[15:12] == 4'b1010);
  assign eof     = (bit_cnt_q == 4'd15);

  // Next-state logic: alignment FSM plus frame delivery on the boundary edge.
  always_comb begin
    state_d         = state_q;
    sr_d            = win[15:1];
    bit_cnt_d       = bit_cnt_q;
    vcnt_d          = vcnt_q;
    mcnt_d          = mcnt_q;
    frame_d         = frame_q;
    frame_valid_d   = 1'b0;
    frame_changed_d = 1'b0;
    sync_err_d      = 1'b0;
    frame_count_d   = frame_count_q;
    deliver         = 1'b0;

    if (!capture_en) begin
      state_d   = HUNT;
      vcnt_d    = '0;
      mcnt_d    = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (sync_ok) begin
            vcnt_d    = 3'd1;
            bit_cnt_d = '0;
            if (LOCK_FRAMES == 1) begin
              state_d = LOCKED;
              mcnt_d  = '0;
              deliver = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (eof) begin
            if (sync_ok) begin
              vcnt_d = vcnt_q + 3'd1;
              if ((vcnt_q + 3'd1) == 3'(LOCK_FRAMES)) begin
                state_d = LOCKED;
                mcnt_d  = '0;
                deliver = 1'b1;
              end
            end else begin
              state_d = HUNT;
              vcnt_d  = '0;
            end
          end
        end
        LOCKED: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (eof) begin
            if (sync_ok) begin
              mcnt_d  = '0;
              deliver = 1'b1;
            end else begin
              sync_err_d = 1'b1;
              mcnt_d     = mcnt_q + 3'd1;
              if ((mcnt_q + 3'd1) == 3'(MISS_LIMIT)) begin
                state_d = HUNT;
                vcnt_d  = '0;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    if (deliver) begin
      frame_d         = win[11:0];
      frame_valid_d   = 1'b1;
      frame_changed_d = (win[11:0] != frame_q);
      frame_count_d   = frame_count_q + CNT_W'(1);
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      state_q         <= HUNT;
      sr_q            <= '0;
      bit_cnt_q       <= '0;
      vcnt_q          <= '0;
      mcnt_q          <= '0;
      frame_q         <= '0;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      sync_err_q      <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      sr_q            <= sr_d;
      bit_cnt_q       <= bit_cnt_d;
      vcnt_q          <= vcnt_d;
      mcnt_q          <= mcnt_d;
      frame_q         <= frame_d;
      frame_valid_q   <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
      sync_err_q      <= sync_err_d;
      frame_count_q   <= frame_count_d;
    end
  end

  assign frame         = frame_q;
  assign frame_valid   = frame_valid_q;
  assign frame_changed = frame_changed_q;
  assign locked        = (state_q == LOCKED);
  assign sync_err      = sync_err_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_debug_frame_capture.sv
// Testbench for debug_frame_capture: a tag model streams 16-address frames,
// a frame-level table drives the scenarios and a scoreboard checks deliveries.
module tb_debug_frame_capture;

  logic        debug_clk = 1'b0;
  logic        reset;
  logic        debug_in;
  logic        capture_en;
  logic [11:0] frame;
  logic        frame_valid;
  logic        frame_changed;
  logic        locked;
  logic        sync_err;
  logic [7:0]  frame_count;

  debug_frame_capture #(
    .LOCK_FRAMES(2),
    .MISS_LIMIT (2),
    .CNT_W      (8)
  ) dut (
    .debug_clk    (debug_clk),
    .reset        (reset),
    .debug_in     (debug_in),
    .capture_en   (capture_en),
    .frame        (frame),
    .frame_valid  (frame_valid),
    .frame_changed(frame_changed),
    .locked       (locked),
    .sync_err     (sync_err),
    .frame_count  (frame_count)
  );

  always #5 debug_clk = ~debug_clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] f;
    logic        ch;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic [11:0] data;
    logic        corrupt;  // flip address 13 (sync bit)
    logic [15:0] cap;      // capture_en per address
    logic        v;        // delivery expected at the boundary
    logic        e;        // sync_err expected at the boundary
    logic        l;        // locked expected after the boundary
  } vec_t;

  exp_t        sbq[$];
  logic [11:0] m_frame;
  logic [7:0]  m_count;
  vec_t        vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every delivery pulse must match the oldest pushed expectation.
  always @(negedge debug_clk) begin
    exp_t e;
    if (frame_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got frame %0h expected no delivery", frame);
      end else begin
        e = sbq.pop_front();
        chk("deliv_frame", 32'(frame), 32'(e.f));
        chk("deliv_changed", 32'(frame_changed), 32'(e.ch));
        chk("deliv_count", 32'(frame_count), 32'(e.cnt));
      end
    end
  end

  // One full frame from address 0 to 15; boundary checks after address 15.
  task automatic send_frame(input logic [11:0] d, input logic corrupt, input logic [15:0] cap,
                            input logic v, input logic e, input logic l);
    logic [15:0] bits;
    exp_t        x;
    bits = {4'b1010, d};
    if (corrupt) bits[13] = ~bits[13];
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
    for (int i = 0; i < 16; i++) begin
      debug_in   = bits[i];
      capture_en = cap[i];
      if (i == 15 && v) begin
        x.ch    = (d != m_frame);
        m_frame = d;
        m_count = m_count + 8'd1;
        x.f     = d;
        x.cnt   = m_count;
        sbq.push_back(x);
      end
      @(posedge debug_clk);
      #1;
      chk("sync_err", 32'(sync_err), 32'((i == 15) && e));
    end
    chk("frame_valid", 32'(frame_valid), 32'(v));
    chk("locked", 32'(locked), 32'(l));
    chk("frame_hold", 32'(frame), 32'(m_frame));
    chk("frame_count", 32'(frame_count), 32'(m_count));
    @(negedge debug_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] pat;
    // Lock on 3C6, change to 001, single miss, double miss + relock,
    // late capture start at address 5, capture drop mid-frame, rehunt.
    vt[0]  = '{12'h3C6, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{12'h3C6, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{12'h3C6, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{12'h001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{12'h001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{12'h001, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1};
    vt[6]  = '{12'h001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{12'h001, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{12'h001, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{12'h001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[10] = '{12'h001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[11] = '{12'h301, 1'b0, 16'hFFE0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{12'h301, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[13] = '{12'h301, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[14] = '{12'h301, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vt[15] = '{12'h301, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[16] = '{12'h301, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};

    reset      = 1'b1;
    debug_in   = 1'b0;
    capture_en = 1'b1;
    m_frame    = '0;
    m_count    = '0;
    repeat (2) @(posedge debug_clk);
    #1;
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_changed", 32'(frame_changed), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    reset = 1'b0;

    for (int n = 0; n < 17; n++)
      send_frame(vt[n].data, vt[n].corrupt, vt[n].cap, vt[n].v, vt[n].e, vt[n].l);

    // Asynchronous reset in the middle of a frame while locked.
    pat = 12'h301;
    for (int i = 0; i < 7; i++) begin
      debug_in   = pat[i];
      capture_en = 1'b1;
      @(posedge debug_clk);
      #1;
    end
    chk("pre_rst_locked", 32'(locked), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_frame", 32'(frame), 32'd0);
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_changed", 32'(frame_changed), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_sync_err", 32'(sync_err), 32'd0);
    chk("arst_count", 32'(frame_count), 32'd0);
    @(posedge debug_clk);
    #1;
    reset   = 1'b0;
    m_frame = '0;
    m_count = '0;
    sbq.delete();

    send_frame(12'h3C6, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_frame(12'h3C6, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    // Run the delivery counter through its wrap point.
    for (int n = 0; n < 260; n++)
      send_frame(12'h3C6, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    chk("count_wrap", 32'(frame_count), 32'd5);
    chk("sb_final", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
